// File: rtl/drfm_pkg.sv
// Shared types and constants for the DRFM SDRAM streamer.
package drfm_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CAPTURE,
        ST_PLAYBACK,
        ST_DRAIN,
        ST_DONE
    } state_t;

    localparam logic MODE_CAPTURE  = 1'b0;
    localparam logic MODE_PLAYBACK = 1'b1;

endpackage

// File: rtl/drfm_sync_fifo.sv
// Single-clock FIFO with simultaneous push/pop and a synchronous flush.
// The head word is held in storage, so data pushed on one edge is visible the next cycle.
module drfm_sync_fifo #(
    parameter int DATA_W     = 16,
    parameter int FIFO_DEPTH = 16,
    localparam int PTR_W     = $clog2(FIFO_DEPTH),
    localparam int CNT_W     = PTR_W + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] pop_data,
    output logic              full,
    output logic              empty,
    output logic [CNT_W-1:0]  count
);

    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_reg;
    logic [PTR_W-1:0]  rd_ptr_reg;
    logic [CNT_W-1:0]  count_reg;
    logic              do_push;
    logic              do_pop;

    // A push into a full FIFO is allowed only when a pop frees a slot on the same edge.
    assign do_pop   = pop & ~empty;
    assign do_push  = push & (~full | do_pop);
    assign full     = (count_reg == CNT_W'(FIFO_DEPTH));
    assign empty    = (count_reg == '0);
    assign count    = count_reg;
    assign pop_data = mem[rd_ptr_reg];

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            count_reg <= count_reg + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

endmodule

// File: rtl/drfm_sdram_streamer.sv
// Moves a sample stream to SDRAM (capture) or from SDRAM to a stream (playback)
// over an Avalon-MM master, buffering through a small FIFO.
module drfm_sdram_streamer
    import drfm_pkg::*;
#(
    parameter int DATA_W     = 16,
    parameter int ADDR_W     = 25,
    parameter int FIFO_DEPTH = 16,
    parameter int MAX_RD_OUT = 4
) (
    input  logic                clk_clk,
    input  logic                reset_reset_n,
    input  logic                cfg_start,
    input  logic                cfg_mode,
    input  logic [ADDR_W-1:0]   cfg_base,
    input  logic [ADDR_W-1:0]   cfg_len,
    input  logic                cfg_loop,
    input  logic                cfg_abort,
    output logic                status_busy,
    output logic                status_done,
    output logic                status_overflow,
    input  logic [DATA_W-1:0]   s_in_data,
    input  logic                s_in_valid,
    output logic                s_in_ready,
    output logic [DATA_W-1:0]   m_out_data,
    output logic                m_out_valid,
    input  logic                m_out_ready,
    output logic [ADDR_W-1:0]   mem_address,
    output logic [DATA_W/8-1:0] mem_byteenable_n,
    output logic                mem_chipselect,
    output logic [DATA_W-1:0]   mem_writedata,
    output logic                mem_read_n,
    output logic                mem_write_n,
    input  logic [DATA_W-1:0]   mem_readdata,
    input  logic                mem_readdatavalid,
    input  logic                mem_waitrequest
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int OUT_W = $clog2(MAX_RD_OUT + 1);

    state_t            state_reg, state_next;
    logic              loop_reg, abort_reg, ovf_reg;
    logic [ADDR_W-1:0] base_reg, len_reg, idx_reg, acc_reg, xfer_reg;
    logic [OUT_W-1:0]  out_reg;
    logic              cmd_act_reg, cmd_wr_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic [DATA_W-1:0] wdata_reg;

    logic              in_capture, in_playback, abort_now;
    logic              cmd_accept, cmd_free, wr_issue, rd_issue, cmd_issue, idx_wrap;
    logic              rd_return, out_pop, s_accept;
    logic              fifo_push, fifo_pop, fifo_flush, fifo_full, fifo_empty;
    logic [DATA_W-1:0] fifo_din, fifo_dout;
    logic [CNT_W-1:0]  fifo_count;
    logic [CNT_W:0]    inflight;

    assign in_capture  = (state_reg == ST_CAPTURE);
    assign in_playback = (state_reg == ST_PLAYBACK);
    assign abort_now   = abort_reg | cfg_abort;
    assign cmd_accept  = cmd_act_reg & ~mem_waitrequest;
    assign cmd_free    = ~cmd_act_reg | cmd_accept;

    // Reads issued but not yet returned reserve FIFO space, so returning data always fits.
    assign inflight  = (CNT_W+1)'(out_reg) + (CNT_W+1)'(fifo_count);
    assign wr_issue  = in_capture & cmd_free & ~abort_now & ~fifo_empty & (idx_reg < len_reg);
    assign rd_issue  = in_playback & cmd_free & ~abort_now & (idx_reg < len_reg)
                     & (out_reg < OUT_W'(MAX_RD_OUT)) & (inflight < (CNT_W+1)'(FIFO_DEPTH));
    assign cmd_issue = wr_issue | rd_issue;
    assign idx_wrap  = loop_reg & in_playback & ((idx_reg + ADDR_W'(1)) == len_reg);

    assign rd_return  = mem_readdatavalid & (out_reg != '0) & (in_playback | (state_reg == ST_DRAIN));
    assign out_pop    = in_playback & ~fifo_empty & m_out_ready;
    assign s_in_ready = in_capture & ~fifo_full & (acc_reg < len_reg) & ~abort_reg;
    assign s_accept   = s_in_valid & s_in_ready;

    assign fifo_push  = s_accept | (in_playback & rd_return);
    assign fifo_pop   = wr_issue | out_pop;
    assign fifo_flush = (state_reg == ST_DRAIN) | (state_reg == ST_IDLE);
    assign fifo_din   = in_capture ? s_in_data : mem_readdata;

    drfm_sync_fifo #(
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk_clk),
        .rst_n     (reset_reset_n),
        .flush     (fifo_flush),
        .push      (fifo_push),
        .push_data (fifo_din),
        .pop       (fifo_pop),
        .pop_data  (fifo_dout),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (cfg_start) begin
                    if (cfg_len == '0)                  state_next = ST_DONE;
                    else if (cfg_mode == MODE_PLAYBACK) state_next = ST_PLAYBACK;
                    else                                state_next = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                if (cmd_accept && ((xfer_reg + ADDR_W'(1)) == len_reg)) state_next = ST_DONE;
                else if (abort_now && cmd_free)                         state_next = ST_DRAIN;
            end
            ST_PLAYBACK: begin
                if (abort_now && cmd_free) state_next = ST_DRAIN;
                else if (!loop_reg && out_pop && ((xfer_reg + ADDR_W'(1)) == len_reg))
                    state_next = ST_DONE;
            end
            ST_DRAIN: begin
                if (out_reg == '0) state_next = ST_DONE;
            end
            ST_DONE:  state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            loop_reg    <= 1'b0;
            abort_reg   <= 1'b0;
            ovf_reg     <= 1'b0;
            base_reg    <= '0;
            len_reg     <= '0;
            idx_reg     <= '0;
            acc_reg     <= '0;
            xfer_reg    <= '0;
            out_reg     <= '0;
            cmd_act_reg <= 1'b0;
            cmd_wr_reg  <= 1'b0;
            addr_reg    <= '0;
            wdata_reg   <= '0;
        end else begin
            if (state_reg == ST_IDLE && cfg_start) begin
                loop_reg  <= cfg_loop;
                base_reg  <= cfg_base;
                len_reg   <= cfg_len;
                idx_reg   <= '0;
                acc_reg   <= '0;
                xfer_reg  <= '0;
                ovf_reg   <= 1'b0;
                abort_reg <= 1'b0;
            end else begin
                if ((in_capture || in_playback) && cfg_abort) abort_reg <= 1'b1;
                if (in_capture && s_in_valid && !s_in_ready && (acc_reg < len_reg) && !abort_reg)
                    ovf_reg <= 1'b1;
                if (s_accept)  acc_reg <= acc_reg + ADDR_W'(1);
                if (cmd_issue) idx_reg <= idx_wrap ? '0 : idx_reg + ADDR_W'(1);
                if ((in_capture && cmd_accept) || out_pop) xfer_reg <= xfer_reg + ADDR_W'(1);
            end
            // Command registers change only when idle or on the accepting edge.
            if (cmd_issue) begin
                cmd_act_reg <= 1'b1;
                cmd_wr_reg  <= in_capture;
                addr_reg    <= base_reg + idx_reg;
                if (wr_issue) wdata_reg <= fifo_dout;
            end else if (cmd_accept) begin
                cmd_act_reg <= 1'b0;
            end
            out_reg <= out_reg + OUT_W'(rd_issue) - OUT_W'(rd_return);
        end
    end

    assign status_busy      = (state_reg != ST_IDLE);
    assign status_done      = (state_reg == ST_DONE);
    assign status_overflow  = ovf_reg;
    assign m_out_data       = fifo_dout;
    assign m_out_valid      = in_playback & ~fifo_empty;
    assign mem_address      = addr_reg;
    assign mem_byteenable_n = '0;
    assign mem_chipselect   = cmd_act_reg;
    assign mem_writedata    = wdata_reg;
    assign mem_write_n      = ~(cmd_act_reg & cmd_wr_reg);
    assign mem_read_n       = ~(cmd_act_reg & ~cmd_wr_reg);

endmodule
